// File: rtl/ps2_keymap_rx.sv
// rtl/ps2_keymap_rx.sv - PS/2 keyboard receiver with E0/F0 scancode decoding and held-key bitmap
module ps2_keymap_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  output logic [31:0] key_word,
  output logic        scan_valid,
  output logic [7:0]  scan_code,
  output logic        scan_ext,
  output logic        scan_brk,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic          ext_flag;
  logic          brk_flag;
  logic [WW-1:0] wd;
  logic [9:0]    key_bits;
  logic [4:0]    hit;

  // Both pins idle high, so the synchronisers reset to 1 to avoid a fake edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
    end
  end

  assign filt_flip = (clk_sync[1] != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && clk_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Returns {hit, bit index}; the E0 prefix is part of the match key.
  function automatic logic [4:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    case ({ext, code})
      9'h175:  r = {1'b1, 4'd0};
      9'h172:  r = {1'b1, 4'd1};
      9'h16B:  r = {1'b1, 4'd2};
      9'h174:  r = {1'b1, 4'd3};
      9'h029:  r = {1'b1, 4'd4};
      9'h05A:  r = {1'b1, 4'd5};
      9'h01D:  r = {1'b1, 4'd6};
      9'h01C:  r = {1'b1, 4'd7};
      9'h01B:  r = {1'b1, 4'd8};
      9'h023:  r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign hit      = key_lookup(ext_flag, shreg);
  assign key_word = {22'd0, key_bits};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      par_ok     <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      wd         <= '0;
      key_bits   <= 10'd0;
      scan_valid <= 1'b0;
      scan_code  <= 8'd0;
      scan_ext   <= 1'b0;
      scan_brk   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall) wd <= '0;
      else                       wd <= wd + 1'b1;

      if (fall) begin
        unique case (state)
          IDLE: begin
            if (!data_sync[1]) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, data_sync[1]};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_sync[1] && par_ok) begin
              if (shreg == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk_flag <= 1'b1;
              end else begin
                scan_valid <= 1'b1;
                scan_code  <= shreg;
                scan_ext   <= ext_flag;
                scan_brk   <= brk_flag;
                ext_flag   <= 1'b0;
                brk_flag   <= 1'b0;
                if (hit[4]) key_bits[hit[3:0]] <= ~brk_flag;
              end
            end else begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && wd == WW'(TIMEOUT_CYCLES - 1)) begin
        // Keyboard stalled mid-frame: drop the partial byte and any pending prefix.
        frame_err <= 1'b1;
        state     <= IDLE;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keymap_rx.sv
// tb/tb_ps2_keymap_rx.sv - randomized self-checking bench for ps2_keymap_rx
module tb_ps2_keymap_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 400;
  localparam int LAT        = 2 + FILTER_LEN;
  localparam logic [8:0] KEYMAP [10] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029,
                                         9'h05A, 9'h01D, 9'h01C, 9'h01B, 9'h023};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] key_word;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        scan_ext;
  logic        scan_brk;
  logic        frame_err;

  ps2_keymap_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .key_word(key_word), .scan_valid(scan_valid), .scan_code(scan_code),
    .scan_ext(scan_ext), .scan_brk(scan_brk), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    bit          err;
    logic [7:0]  code;
    bit          ext;
    bit          brk;
    logic [31:0] key;
  } ev_t;

  ev_t         evq[$];
  ev_t         cur;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          sv_count = 0;
  int          fe_count = 0;
  int          last_fall = 0;
  bit          chk_en = 1'b0;
  bit          m_ext, m_brk;
  logic [31:0] m_key;
  logic [7:0]  e_code;
  bit          e_ext, e_brk;
  logic [31:0] e_key;
  bit          exp_sv, exp_fe;
  int          n0, f0, t0, r;
  bit          got;
  logic [8:0]  km;
  logic [7:0]  rb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_key = '0;
    e_code = '0; e_ext = 0; e_brk = 0; e_key = '0;
    evq.delete();
  endtask

  task automatic model_err(input int t);
    ev_t e;
    e.t = t; e.err = 1; e.code = '0; e.ext = 0; e.brk = 0; e.key = m_key;
    evq.push_back(e);
    m_ext = 0; m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    ev_t e;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      for (int i = 0; i < 10; i++)
        if (KEYMAP[i] == {m_ext, b}) m_key[i] = !m_brk;
      e.t = t; e.err = 0; e.code = b; e.ext = m_ext; e.brk = m_brk; e.key = m_key;
      evq.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Drives the first nbits of a frame; a short frame is expected to end in a watchdog error.
  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit sbad,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    int half;
    half = $urandom_range(12, 7);
    f = {~sbad, (~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cycles(half);
      if (i == glitch_bit) begin
        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
        wait_cycles(half);
      end
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        if (pflip || sbad) model_err(cyc + LAT);
        else               model_byte(b, cyc + LAT);
      end
      wait_cycles(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits < 11) model_err(last_fall + LAT + TIMEOUT);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1);
    wait_cycles($urandom_range(6, 0));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_sv = 0;
      exp_fe = 0;
      while (evq.size() > 0 && evq[0].t < cyc) begin
        chk("event_missed", evq[0].t, cyc);
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].t == cyc) begin
        cur = evq.pop_front();
        if (cur.err) exp_fe = 1;
        else begin
          exp_sv = 1; e_code = cur.code; e_ext = cur.ext; e_brk = cur.brk; e_key = cur.key;
        end
      end
      chk("scan_valid", scan_valid, exp_sv);
      chk("frame_err", frame_err, exp_fe);
      chk("key_word", key_word, e_key);
      chk("scan_code", scan_code, e_code);
      chk("scan_ext", scan_ext, e_ext);
      chk("scan_brk", scan_brk, e_brk);
      if (scan_valid) sv_count++;
      if (frame_err) fe_count++;
    end
  end

  initial begin
    reset = 1'b1;
    wait_cycles(4);
    chk("rst_key_word", key_word, 32'h0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_scan_code", scan_code, 8'h00);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    model_clear();
    chk_en = 1'b1;
    wait_cycles(5);

    send(8'h1D);
    chk("w_make_key", key_word, 32'h40);
    chk("w_make_code", scan_code, 8'h1D);
    chk("w_make_brk", scan_brk, 0);

    n0 = sv_count;
    send(8'hF0);
    send(8'h1D);
    chk("w_break_pulses", sv_count - n0, 1);
    chk("w_break_brk", scan_brk, 1);
    chk("w_break_key", key_word, 32'h0);

    send(8'hE0); send(8'h75);
    chk("up_make_key", key_word, 32'h1);
    chk("up_make_ext", scan_ext, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_break_key", key_word, 32'h0);
    chk("up_break_flags", {scan_ext, scan_brk}, 2'b11);
    send(8'h75);
    chk("bare75_key", key_word, 32'h0);
    chk("bare75_ext", scan_ext, 0);

    n0 = sv_count; f0 = fe_count;
    send_frame(8'h29, 1'b1, 1'b0, 11, -1);
    wait_cycles(3);
    chk("par_err_pulses", fe_count - f0, 1);
    chk("par_err_no_valid", sv_count - n0, 0);
    chk("par_err_key", key_word, 32'h0);
    send(8'h29);
    chk("space_key", key_word, 32'h10);
    send(8'hF0); send(8'h29);

    send_frame(8'h5A, 1'b0, 1'b0, 6, -1);
    t0 = last_fall;
    got = 0;
    for (int k = 0; k < TIMEOUT + 50 && !got; k++) begin
      wait_cycles(1);
      if (frame_err) begin
        chk("timeout_latency", cyc - t0, LAT + TIMEOUT);
        got = 1;
      end
    end
    chk("timeout_seen", got, 1);
    wait_cycles(5);
    send(8'h5A);
    chk("enter_key", key_word, 32'h20);

    send_frame(8'h1C, 1'b0, 1'b0, 11, 0);
    chk("glitch_start_key", key_word, 32'hA0);
    send_frame(8'h1B, 1'b0, 1'b0, 11, 4);
    chk("glitch_data_key", key_word, 32'h1A0);

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(99, 0);
      km = KEYMAP[$urandom_range(9, 0)];
      if (r < 15)      rb = 8'hE0;
      else if (r < 30) rb = 8'hF0;
      else if (r < 75) rb = km[7:0];
      else             rb = 8'($urandom);
      if ($urandom_range(39, 0) == 0) begin
        send_frame(rb, 1'b0, 1'b0, $urandom_range(10, 1), -1);
        wait_cycles(TIMEOUT + LAT + 10);
      end else begin
        send_frame(rb, $urandom_range(19, 0) == 0, $urandom_range(24, 0) == 0, 11,
                   ($urandom_range(7, 0) == 0) ? $urandom_range(10, 0) : -1);
        wait_cycles($urandom_range(20, 0));
      end
    end

    send(8'h77);
    for (int i = 0; i < 10; i++) begin
      km = KEYMAP[i];
      if (km[8]) send(8'hE0);
      send(km[7:0]);
    end
    chk("all_keys_held", key_word, 32'h3FF);

    send_frame(8'h23, 1'b0, 1'b0, 4, -1);
    chk_en = 1'b0;
    reset = 1'b1;
    wait_cycles(1);
    chk("midrst_key_word", key_word, 32'h0);
    chk("midrst_outputs", {scan_valid, scan_code, scan_ext, scan_brk, frame_err}, 12'h0);
    wait_cycles(2);
    reset = 1'b0;
    model_clear();
    chk_en = 1'b1;
    wait_cycles(5);
    send(8'h23);
    chk("post_rst_key", key_word, 32'h200);
    chk("post_rst_code", scan_code, 8'h23);

    wait_cycles(LAT + 5);
    chk("queue_drained", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
